// File: rtl/vend_fsm_param_if.sv
// Button/switch inputs and credit/dispense/change outputs of the vending controller.
// master = front panel side, slave = controller side.
interface vend_fsm_param_if #(
  parameter int unsigned N_ITEMS = 4,
  parameter int unsigned AMT_W   = 8
);
  logic [2:0]         coin_btn;
  logic               cancel;
  logic [N_ITEMS-1:0] sel;
  logic [AMT_W-1:0]   credit;
  logic [AMT_W-1:0]   price;
  logic [N_ITEMS-1:0] vend_led;
  logic [AMT_W-1:0]   change;
  logic               change_valid;
  logic               coin_reject;
  logic               busy;

  modport master (
    output coin_btn, cancel, sel,
    input  credit, price, vend_led, change, change_valid, coin_reject, busy
  );

  modport slave (
    input  coin_btn, cancel, sel,
    output credit, price, vend_led, change, change_valid, coin_reject, busy
  );
endinterface

// File: rtl/vend_fsm_param.sv
// Parametrised vending-machine controller: coin accumulation with ceiling,
// one-hot item select, multi-cycle dispense, cancel/refund and change output.
module vend_fsm_param #(
  parameter int unsigned N_ITEMS         = 4,
  parameter int unsigned AMT_W           = 8,
  parameter logic [N_ITEMS*AMT_W-1:0] PRICES = {8'd30, 8'd25, 8'd20, 8'd15},
  parameter int unsigned COIN0           = 5,
  parameter int unsigned COIN1           = 10,
  parameter int unsigned COIN2           = 25,
  parameter int unsigned MAX_CREDIT      = 95,
  parameter int unsigned DISPENSE_CYCLES = 2
) (
  input  logic              clk_1Hz,
  input  logic              clr,
  vend_fsm_param_if.slave   bus
);

  localparam int unsigned CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DISPENSE_CYCLES - 1);
  localparam logic [AMT_W:0]   CEILING  = (AMT_W+1)'(MAX_CREDIT);
  localparam logic [AMT_W-1:0] C0 = AMT_W'(COIN0);
  localparam logic [AMT_W-1:0] C1 = AMT_W'(COIN1);
  localparam logic [AMT_W-1:0] C2 = AMT_W'(COIN2);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t             state, state_d;
  logic [AMT_W-1:0]   credit_q, credit_d;
  logic [AMT_W-1:0]   change_q, change_d;
  logic [N_ITEMS-1:0] vend_q, vend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               reject_q, reject_d;
  logic [2:0]         coin_q;
  logic               cancel_q;

  logic [2:0]         coin_edge;
  logic               cancel_edge;
  logic               coin_any;
  logic [AMT_W-1:0]   coin_val;
  logic [AMT_W:0]     coin_sum;
  logic [AMT_W-1:0]   price_sel;
  logic [AMT_W-1:0]   price_out;
  logic               onehot;
  logic               sel_valid;

  assign coin_edge   = bus.coin_btn & ~coin_q;
  assign cancel_edge = bus.cancel & ~cancel_q;
  assign coin_any    = |coin_edge;

  always_comb begin
    price_sel = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (bus.sel[i]) price_sel = price_sel | PRICES[i*AMT_W +: AMT_W];
    end
    onehot    = (bus.sel != '0) && ((bus.sel & (bus.sel - N_ITEMS'(1))) == '0);
    sel_valid = onehot && (price_sel != '0);
    price_out = sel_valid ? price_sel : '0;
  end

  // Lowest-numbered button wins; other simultaneous edges are discarded.
  always_comb begin
    coin_val = '0;
    if (coin_edge[0])      coin_val = C0;
    else if (coin_edge[1]) coin_val = C1;
    else if (coin_edge[2]) coin_val = C2;
    coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
  end

  always_comb begin
    state_d  = state;
    credit_d = credit_q;
    change_d = change_q;
    vend_d   = vend_q;
    cnt_d    = cnt_q;
    reject_d = 1'b0;
    case (state)
      IDLE, CREDIT: begin
        if (cancel_edge && (credit_q != '0)) begin
          state_d  = CHANGE;
          change_d = credit_q;
          credit_d = '0;
          reject_d = coin_any;
        end else if (sel_valid && (credit_q >= price_out)) begin
          state_d  = VEND;
          credit_d = credit_q - price_out;
          vend_d   = bus.sel;
          cnt_d    = CNT_LOAD;
          reject_d = coin_any;
        end else if (coin_any) begin
          if (coin_sum <= CEILING) begin
            credit_d = coin_sum[AMT_W-1:0];
            state_d  = CREDIT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      VEND: begin
        reject_d = coin_any;
        if (cnt_q == '0) begin
          vend_d = '0;
          if (credit_q != '0) begin
            state_d  = CHANGE;
            change_d = credit_q;
            credit_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CHANGE: begin
        reject_d = coin_any;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge registers reset high so a button held through reset is not counted.
  always_ff @(posedge clk_1Hz or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      credit_q <= '0;
      change_q <= '0;
      vend_q   <= '0;
      cnt_q    <= '0;
      reject_q <= 1'b0;
      coin_q   <= '1;
      cancel_q <= 1'b1;
    end else begin
      state    <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      vend_q   <= vend_d;
      cnt_q    <= cnt_d;
      reject_q <= reject_d;
      coin_q   <= bus.coin_btn;
      cancel_q <= bus.cancel;
    end
  end

  assign bus.credit       = credit_q;
  assign bus.price        = price_out;
  assign bus.vend_led     = vend_q;
  assign bus.change       = change_q;
  assign bus.change_valid = (state == CHANGE);
  assign bus.coin_reject  = reject_q;
  assign bus.busy         = (state == VEND) || (state == CHANGE);

endmodule
